adj_scan_engine: RTL and testbench

ADJ_SCAN_ENGINE -- requirements
Module: adj_scan_engine

---
 rtl/adj_scan_engine.sv | 136 +++++++++++++
 tb/tb_adj_scan_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adj_scan_engine.sv
// Mine-adjacency scan engine.
// A start request snapshots the mine map, then LANES tiles per clock have
// their mined-neighbour count written into the adj register. After BEATS
// beats the engine parks in DONE with adj stable until the next start.
//
// state | meaning
// IDLE  | waiting for start after reset
// SCAN  | writing LANES tile counts per beat from the snapshot
// DONE  | adj valid and held until start re-launches a run
module adj_scan_engine #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int LANES = 1,
    parameter int WRAP  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ROWS*COLS-1:0]       mine_map,
    output logic [ROWS*COLS*4-1:0]     adj,
    output logic                       busy,
    output logic                       done
);

    localparam int TOTAL = ROWS * COLS;
    localparam int BEATS = (TOTAL + LANES - 1) / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BW-1:0]       beat;
    logic [TOTAL-1:0]    snap;
    logic [3:0]          cnt [TOTAL];
    logic [TOTAL*4-1:0]  adj_nxt;
    logic                launch;
    int                  nr;
    int                  nc;
    int                  tile;

    // Start is only honoured from IDLE or DONE; requests during SCAN are dropped.
    assign launch = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == SCAN);
    assign done   = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? SCAN : IDLE;
            SCAN:    state_nxt = (beat == LAST_BEAT) ? DONE : SCAN;
            DONE:    state_nxt = start ? SCAN : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= '0;
            beat <= '0;
        end else if (launch) begin
            snap <= mine_map;
            beat <= '0;
        end else if ((state == SCAN) && (beat != LAST_BEAT)) begin
            beat <= beat + 1'b1;
        end
    end

    // Neighbour counts for every tile, taken from the snapshot only.
    always_comb begin
        nr = 0;
        nc = 0;
        for (int t = 0; t < TOTAL; t++) begin
            cnt[t] = '0;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0) || (dc != 0)) begin
                            nr = r + dr;
                            nc = c + dc;
                            if (WRAP != 0) begin
                                nr = (nr + ROWS) % ROWS;
                                nc = (nc + COLS) % COLS;
                            end
                            if ((nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS)) begin
                                cnt[r*COLS + c] = cnt[r*COLS + c] + {3'b000, snap[nr*COLS + nc]};
                            end
                        end
                    end
                end
            end
        end
    end

    // Merge this beat's lane results; tiles past TOTAL on the last beat are skipped.
    always_comb begin
        adj_nxt = adj;
        tile    = 0;
        if (state == SCAN) begin
            for (int l = 0; l < LANES; l++) begin
                tile = int'(beat) * LANES + l;
                if (tile < TOTAL) begin
                    adj_nxt[tile*4 +: 4] = cnt[tile];
                end
            end
        end
    end

    // Result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adj <= '0;
        end else begin
            adj <= adj_nxt;
        end
    end

endmodule

// File: tb/tb_adj_scan_engine.sv
// Bench for adj_scan_engine: three 5x5 instances (plain, toroidal, 4-lane)
// share stimulus; expected maps are queued at launch and popped at done.
module tb_adj_scan_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [24:0] mine_map = '0;
    logic [99:0] adj0, adjw, adj4;
    logic        busy0, done0, busyw, donew, busy4, done4;

    int total = 0;
    int bad   = 0;
    int busy4_cnt = 0;

    logic [99:0] q0 [$];
    logic [99:0] qw [$];
    logic [99:0] q4 [$];

    always #5 clk = ~clk;

    adj_scan_engine #(.ROWS(5), .COLS(5), .LANES(1), .WRAP(0)) u_plain (
        .clk(clk), .rst(rst), .start(start), .mine_map(mine_map),
        .adj(adj0), .busy(busy0), .done(done0));

    adj_scan_engine #(.ROWS(5), .COLS(5), .LANES(1), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .mine_map(mine_map),
        .adj(adjw), .busy(busyw), .done(donew));

    adj_scan_engine #(.ROWS(5), .COLS(5), .LANES(4), .WRAP(0)) u_lane4 (
        .clk(clk), .rst(rst), .start(start), .mine_map(mine_map),
        .adj(adj4), .busy(busy4), .done(done4));

    // Reference: tile j neighbours tile i when row and column distances are both <= 1.
    function automatic logic [99:0] model(input logic [24:0] m, input bit wrap);
        logic [99:0] r;
        int cnt, dr, dc;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            cnt = 0;
            for (int j = 0; j < 25; j++) begin
                if (j != i) begin
                    dr = i / 5 - j / 5;
                    dc = i % 5 - j % 5;
                    if (dr < 0) dr = -dr;
                    if (dc < 0) dc = -dc;
                    if (wrap && (5 - dr < dr)) dr = 5 - dr;
                    if (wrap && (5 - dc < dc)) dc = 5 - dc;
                    if ((dr <= 1) && (dc <= 1) && m[j]) cnt++;
                end
            end
            r[i*4 +: 4] = 4'(cnt);
        end
        return r;
    endfunction

    function automatic logic [99:0] ones_at(input logic [24:0] mask);
        logic [99:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) r[i*4 +: 4] = mask[i] ? 4'd1 : 4'd0;
        return r;
    endfunction

    function automatic logic [99:0] full_grid();
        logic [99:0] r;
        int edges;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            edges = 0;
            if ((i / 5 == 0) || (i / 5 == 4)) edges++;
            if ((i % 5 == 0) || (i % 5 == 4)) edges++;
            r[i*4 +: 4] = (edges == 2) ? 4'd3 : (edges == 1) ? 4'd5 : 4'd8;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [24:0] m, input string tag);
        @(negedge clk);
        mine_map = m;
        start    = 1'b1;
        q0.push_back(model(m, 1'b0));
        qw.push_back(model(m, 1'b1));
        q4.push_back(model(m, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "/launch_busy_done"}, {98'b0, busy0, done0}, 100'b10);
        busy4_cnt = busy4 ? 1 : 0;
    endtask

    task automatic run_wait(input string tag, input int inj_edge, input logic [24:0] inj_map);
        int n0, nw, n4;
        n0 = -1;
        nw = -1;
        n4 = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (busy4) busy4_cnt++;
            if (done0 && (n0 < 0)) n0 = n;
            if (donew && (nw < 0)) nw = n;
            if (done4 && (n4 < 0)) n4 = n;
            if (n == inj_edge) begin
                mine_map = inj_map;
                start    = 1'b1;
            end else if (n == inj_edge + 1) begin
                start = 1'b0;
            end
        end
        chk({tag, "/lat_plain"}, 100'(n0), 100'd25);
        chk({tag, "/lat_wrap"},  100'(nw), 100'd25);
        chk({tag, "/lat_lane4"}, 100'(n4), 100'd7);
        chk({tag, "/busy_cycles_lane4"}, 100'(busy4_cnt), 100'd7);
        chk({tag, "/adj_plain"}, adj0, q0.pop_front());
        chk({tag, "/adj_wrap"},  adjw, qw.pop_front());
        chk({tag, "/adj_lane4"}, adj4, q4.pop_front());
    endtask

    initial begin
        logic [24:0] m;
        int stray;

        #2;
        chk("reset/adj_plain", adj0, 100'd0);
        chk("reset/adj_wrap",  adjw, 100'd0);
        chk("reset/adj_lane4", adj4, 100'd0);
        chk("reset/flags", {94'b0, busy0, done0, busyw, donew, busy4, done4}, 100'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold/flags", {98'b0, busy0, done0}, 100'd0);

        launch(25'h1 << 12, "centre");
        run_wait("centre", -1, '0);
        m = '0;
        m[6] = 1'b1; m[7] = 1'b1; m[8] = 1'b1; m[11] = 1'b1;
        m[13] = 1'b1; m[16] = 1'b1; m[17] = 1'b1; m[18] = 1'b1;
        chk("centre/explicit", adj0, ones_at(m));

        launch(25'h1, "corner");
        run_wait("corner", -1, '0);
        m = '0;
        m[1] = 1'b1; m[5] = 1'b1; m[6] = 1'b1;
        chk("corner/explicit_plain", adj0, ones_at(m));
        m[4] = 1'b1; m[9] = 1'b1; m[20] = 1'b1; m[21] = 1'b1; m[24] = 1'b1;
        chk("corner/explicit_wrap", adjw, ones_at(m));

        launch('1, "full");
        run_wait("full", -1, '0);
        chk("full/explicit_lane4", adj4, full_grid());

        launch(25'h0A5_3C1, "snapshot");
        run_wait("snapshot", 3, '1);

        launch(25'($urandom), "rand1");
        run_wait("rand1", -1, '0);
        launch(25'($urandom), "rand2");
        run_wait("rand2", -1, '0);

        @(negedge clk);
        mine_map = 25'($urandom) | 25'h1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset/adj_plain", adj0, 100'd0);
        chk("midreset/adj_wrap",  adjw, 100'd0);
        chk("midreset/adj_lane4", adj4, 100'd0);
        chk("midreset/flags", {94'b0, busy0, done0, busyw, donew, busy4, done4}, 100'd0);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done0 || busy0 || done4 || busy4) stray++;
        end
        chk("midreset/no_completion", 100'(stray), 100'd0);

        launch(25'($urandom), "post_reset");
        run_wait("post_reset", -1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
